// File: rtl/fb_sched_pkg.sv
// Shared constants for the frame-buffer access scheduler.
//   OP_READ / OP_WR_WORD : engine op encodings (op is a byte-enable mask, 0 = read)
//   ENG_*                : engine port indices
//   TAG_SCAN             : rd_tag bit that marks a scanout read (default NUM_REQ)
//   ADDR_W_DEF/DATA_W_DEF: default memory geometry
package fb_sched_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 17;
    localparam int DATA_W_DEF  = 32;

    localparam logic [3:0] OP_READ    = 4'b0000;
    localparam logic [3:0] OP_WR_WORD = 4'b1111;

    localparam int ENG_FETCH  = 0;
    localparam int ENG_LINE   = 1;
    localparam int ENG_CIRCLE = 2;

    localparam int TAG_SCAN = NUM_REQ_DEF;

endpackage

// File: rtl/fb_access_scheduler_rr_picker.sv
// Combinational round-robin select.
//   req : request vector
//   ptr : index that has first claim this cycle
//   gnt : one-hot grant to the first requester at or after ptr (wrapping), or zero
module rr_picker
    import fb_sched_pkg::*;
#(
    parameter int N     = NUM_REQ_DEF,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_access_scheduler.sv
// Single-port pixel/command RAM arbiter: one scanout reader plus NUM_REQ engines.
//   scan_rts/scan_addr/scan_rtr        : scanout read request handshake
//   req_rts/req_op/req_addr/req_wrdata : per-engine request (op = byte mask, 0 = read)
//   req_rtr                            : per-engine accept, one-hot or zero
//   mem_addr/wben/mem_data_out         : registered RAM command
//   mem_data_in                        : RAM read data, RD_LAT cycles after mem_addr
//   rd_valid/rd_tag/rd_data            : tagged read return (tag bit NUM_REQ = scanout)
module fb_access_scheduler
    import fb_sched_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       scan_rts,
    input  logic [ADDR_W-1:0]          scan_addr,
    output logic                       scan_rtr,
    input  logic [NUM_REQ-1:0]         req_rts,
    input  logic [4*NUM_REQ-1:0]       req_op,
    input  logic [ADDR_W*NUM_REQ-1:0]  req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]  req_wrdata,
    output logic [NUM_REQ-1:0]         req_rtr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [3:0]                 wben,
    output logic [DATA_W-1:0]          mem_data_out,
    input  logic [DATA_W-1:0]          mem_data_in,
    output logic                       rd_valid,
    output logic [NUM_REQ:0]           rd_tag,
    output logic [DATA_W-1:0]          rd_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starved, starved_gnt, normal_gnt, eng_gnt;

    logic [3:0]        sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NUM_REQ:0]  issue_tag;

    logic [NUM_REQ:0]  tag_p [RD_LAT+1];
    logic [NUM_REQ:0]  tag_cap;
    logic [DATA_W-1:0] data_cap;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            starved[i] = req_rts[i] && (cnt[i] == CNT_W'(STARVE_MAX));
    end

    rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_starved_pick (
        .req (starved),
        .ptr (ptr),
        .gnt (starved_gnt)
    );

    rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_normal_pick (
        .req (req_rts),
        .ptr (ptr),
        .gnt (normal_gnt)
    );

    // Arbitration: starved engines, then scanout, then round-robin engines
    always_comb begin
        eng_gnt  = '0;
        scan_rtr = 1'b0;
        if (!rst_) begin
            eng_gnt  = '0;
        end else if (|starved) begin
            eng_gnt  = starved_gnt;
        end else if (scan_rts) begin
            scan_rtr = 1'b1;
        end else begin
            eng_gnt  = normal_gnt;
        end
    end

    assign req_rtr = eng_gnt;

    always_comb begin
        sel_op   = OP_READ;
        sel_addr = scan_addr;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eng_gnt[i]) begin
                sel_op   = req_op[4*i +: 4];
                sel_addr = req_addr[ADDR_W*i +: ADDR_W];
                sel_data = req_wrdata[DATA_W*i +: DATA_W];
            end
        end
        // Only reads are tracked for return; writes leave the tag empty.
        issue_tag = {scan_rtr, eng_gnt & {NUM_REQ{sel_op == OP_READ}}};
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_rts[i] || eng_gnt[i])
                    cnt[i] <= '0;
                else if (cnt[i] != CNT_W'(STARVE_MAX))
                    cnt[i] <= cnt[i] + 1'b1;
                if (eng_gnt[i])
                    ptr <= PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // Issue stage: RAM command register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_addr     <= '0;
            wben         <= '0;
            mem_data_out <= '0;
        end else begin
            wben <= OP_READ;
            if (scan_rtr) begin
                mem_addr <= scan_addr;
            end else if (|eng_gnt) begin
                mem_addr <= sel_addr;
                wben     <= sel_op;
                if (sel_op != OP_READ)
                    mem_data_out <= sel_data;
            end
        end
    end

    // Return path: tag delay line, RAM data capture, then output register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int k = 0; k <= RD_LAT; k++) tag_p[k] <= '0;
            tag_cap  <= '0;
            data_cap <= '0;
            rd_valid <= 1'b0;
            rd_tag   <= '0;
            rd_data  <= '0;
        end else begin
            tag_p[0] <= issue_tag;
            for (int k = 1; k <= RD_LAT; k++) tag_p[k] <= tag_p[k-1];
            tag_cap <= tag_p[RD_LAT];
            if (|tag_p[RD_LAT])
                data_cap <= mem_data_in;
            rd_valid <= |tag_cap;
            rd_tag   <= tag_cap;
            if (|tag_cap)
                rd_data <= data_cap;
        end
    end

endmodule
